// File: rtl/mem_dump_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_dump_tx_if : control, memory read port and UART pins of the dump  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_dump_tx_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, length, mem_data,
    input  mem_addr, mem_rd, tx, busy, done
  );

  modport slave (
    input  start, start_addr, length, mem_data,
    output mem_addr, mem_rd, tx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mem_dump_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_dump_tx : walks a memory range and sends each byte as UART 8N1    |
// | Optional even parity bit when DUMP_PARITY_EN is defined. Rev 1.0     |
// +----------------------------------------------------------------------+
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_dump_tx_if.slave bus
);
  localparam logic [15:0]     c_baud_last = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_bit_last  = 3'(DATA_W - 1);
  localparam logic [ADDR_W:0] c_full_len  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_len_one   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_shreg;
  logic [15:0]       r_baud;
  logic [2:0]        r_bit;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
`ifdef DUMP_PARITY_EN
  logic              r_parity;
`endif
  logic              w_baud_end;

  assign w_baud_end   = (r_baud == c_baud_last);
  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_shreg     <= '0;
      r_baud      <= '0;
      r_bit       <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
`ifdef DUMP_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_mem_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.start) begin
            // Read strobe is registered, so it is raised on the accepting edge.
            r_addr      <= bus.start_addr;
            r_mem_addr  <= bus.start_addr;
            r_mem_rd    <= 1'b1;
            r_remaining <= (bus.length == '0) ? c_full_len : bus.length;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_shreg <= bus.mem_data;
`ifdef DUMP_PARITY_EN
          r_parity <= ^bus.mem_data;
`endif
          r_addr  <= r_addr + ADDR_W'(1);
          r_baud  <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shreg[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == c_bit_last) begin
`ifdef DUMP_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shreg <= r_shreg >> 1;
              r_tx    <= r_shreg[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
`ifdef DUMP_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_end) begin
            r_baud      <= '0;
            r_remaining <= r_remaining - c_len_one;
            if (r_remaining == c_len_one) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_mem_addr <= r_addr;
              r_mem_rd   <= 1'b1;
              r_state    <= S_FETCH;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_dump_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_dump_tx : randomized dumps against a cycle-level frame model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_dump_tx;
  localparam int C = 4;
`ifdef DUMP_PARITY_EN
  localparam int FRAME = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 10;
  localparam bit PAR   = 1'b0;
`endif

  logic clk;
  logic reset;
  logic [7:0] mem [256];
  int n_cmp;
  int n_err;

  mem_dump_tx_if #(.ADDR_W(8), .DATA_W(8)) bus();

  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory; garbage outside read cycles.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    else            bus.mem_data <= 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_dump(input logic [7:0] addr, input logic [8:0] len, input int glitch);
    int n;
    logic [7:0] b;
    logic q_tx[$];
    logic q_rd[$];
    logic [7:0] q_addr[$];
    n = (len == 0) ? 256 : int'(len);
    for (int j = 0; j < n; j++) begin
      b = mem[8'(int'(addr) + j)];
      q_tx.push_back(1'b1); q_rd.push_back(1'b1); q_addr.push_back(8'(int'(addr) + j));
      q_tx.push_back(1'b1); q_rd.push_back(1'b0); q_addr.push_back(8'h00);
      for (int f = 0; f < FRAME; f++) begin
        logic bit_v;
        if (f == 0)                bit_v = 1'b0;
        else if (f <= 8)           bit_v = b[f-1];
        else if (PAR && f == 9)    bit_v = ^b;
        else                       bit_v = 1'b1;
        for (int r = 0; r < C; r++) begin
          q_tx.push_back(bit_v); q_rd.push_back(1'b0); q_addr.push_back(8'h00);
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = addr; bus.length = len;
    @(posedge clk);
    for (int k = 0; k < q_tx.size(); k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("tx", 32'(bus.tx), 32'(q_tx[k]));
      check("busy", 32'(bus.busy), 32'd1);
      check("done", 32'(bus.done), 32'd0);
      check("mem_rd", 32'(bus.mem_rd), 32'(q_rd[k]));
      if (q_rd[k]) check("mem_addr", 32'(bus.mem_addr), 32'(q_addr[k]));
      if (k == glitch) begin
        bus.start = 1'b1; bus.start_addr = 8'($urandom); bus.length = 9'($urandom);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_end", 32'(bus.busy), 32'd0);
    check("tx_end", 32'(bus.tx), 32'd1);
    check("mem_rd_end", 32'(bus.mem_rd), 32'd0);
    @(negedge clk);
    check("done_once", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("tx_idle", 32'(bus.tx), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);

    mem[8'h10] = 8'hA5;
    run_dump(8'h10, 9'd1, -1);

    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    run_dump(8'hFE, 9'd3, -1);

    run_dump(8'h30, 9'd2, 25);

    mem[8'h50] = 8'h07; mem[8'h51] = 8'h03;
    run_dump(8'h50, 9'd2, -1);

    // Reset during DATA bit 3 of a byte whose bits are all zero.
    mem[8'h40] = 8'h00;
    mem[8'h20] = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 8'h40; bus.length = 9'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_rst_tx", 32'(bus.tx), 32'd0);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_tx", 32'(bus.tx), 32'd1);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_mem_rd", 32'(bus.mem_rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_dump(8'h20, 9'd1, -1);

    for (int t = 0; t < 8; t++) begin
      int g;
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
      run_dump(8'($urandom), 9'($urandom_range(1, 6)), g);
    end

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    run_dump(8'h00, 9'd0, 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
